// File: rtl/varint_decoder_if.sv
// Varint decoder bus: input FIFO pair (data + index) and the decoded-value output port.
interface varint_decoder_if #(
    parameter int VAL_W = 64,
    parameter int IDX_W = 10
);
    logic             varint_in_fifo_empty;
    logic [31:0]      varint_in_fifo_data;
    logic [IDX_W-1:0] varint_in_index_data;
    logic             varint_in_fifo_pop;
    logic             varint_in_index_pop;
    logic             varint_out_valid;
    logic             varint_out_ready;
    logic [VAL_W-1:0] varint_out_data;
    logic [IDX_W-1:0] varint_out_index;
    logic             varint_out_err;

    // Environment side: FIFOs and downstream consumer
    modport master (
        output varint_in_fifo_empty, varint_in_fifo_data, varint_in_index_data,
        input  varint_in_fifo_pop, varint_in_index_pop,
        input  varint_out_valid, varint_out_data, varint_out_index, varint_out_err,
        output varint_out_ready
    );

    // Decoder side
    modport slave (
        input  varint_in_fifo_empty, varint_in_fifo_data, varint_in_index_data,
        output varint_in_fifo_pop, varint_in_index_pop,
        output varint_out_valid, varint_out_data, varint_out_index, varint_out_err,
        input  varint_out_ready
    );
endinterface

// File: rtl/varint_decoder.sv
// LEB128 varint decoder: consumes one byte per cycle from a show-ahead 32-bit word FIFO,
// emits each decoded value with the index of the word holding its first byte.
module varint_decoder #(
    parameter int MAX_BYTES = 10,
    parameter int VAL_W     = 64,
    parameter int IDX_W     = 10
) (
    input  logic           clk,
    input  logic           reset,
    varint_decoder_if.slave bus
);
    localparam int NB_W = $clog2(MAX_BYTES + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [VAL_W-1:0] acc, acc_nxt;
    logic [NB_W-1:0]  nbytes, nbytes_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [1:0]       byte_sel;
    logic             out_free;
    logic             consume;
    logic             emit;
    logic             emit_err;
    logic             pop;
    logic [7:0]       cur_byte;
    logic [VAL_W-1:0] shifted;

    // Byte consumption, next-state decode and the value the current byte would produce
    always_comb begin
        out_free   = !bus.varint_out_valid || bus.varint_out_ready;
        consume    = !reset && !bus.varint_in_fifo_empty && out_free;
        pop        = consume && (byte_sel == 2'd3);
        cur_byte   = bus.varint_in_fifo_data[{byte_sel, 3'b000} +: 8];
        shifted    = VAL_W'(cur_byte[6:0]) << (32'(nbytes) * 32'd7);
        state_nxt  = state;
        acc_nxt    = acc;
        nbytes_nxt = nbytes;
        idx_nxt    = idx_q;
        emit       = 1'b0;
        emit_err   = 1'b0;
        case (state)
            IDLE: begin
                acc_nxt    = VAL_W'(cur_byte[6:0]);
                nbytes_nxt = NB_W'(1);
                idx_nxt    = bus.varint_in_index_data;
                if (!cur_byte[7]) begin
                    emit = 1'b1;
                end else begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                acc_nxt    = acc | shifted;
                nbytes_nxt = nbytes + NB_W'(1);
                if (!cur_byte[7]) begin
                    emit      = 1'b1;
                    state_nxt = IDLE;
                end else if (nbytes_nxt == NB_W'(MAX_BYTES)) begin
                    emit      = 1'b1;
                    emit_err  = 1'b1;
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (!cur_byte[7]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        bus.varint_in_fifo_pop  = pop;
        bus.varint_in_index_pop = pop;
    end

    // Decode state advances only on cycles that consume a byte; empty FIFO stalls in place
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            nbytes   <= '0;
            idx_q    <= '0;
            byte_sel <= '0;
        end else if (consume) begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            nbytes   <= nbytes_nxt;
            idx_q    <= idx_nxt;
            byte_sel <= byte_sel + 2'd1;
        end
    end

    // Output register: an emit always overwrites (it only happens when the slot is free),
    // otherwise an accept empties the slot
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.varint_out_valid <= 1'b0;
            bus.varint_out_data  <= '0;
            bus.varint_out_index <= '0;
            bus.varint_out_err   <= 1'b0;
        end else if (consume && emit) begin
            bus.varint_out_valid <= 1'b1;
            bus.varint_out_data  <= acc_nxt;
            bus.varint_out_index <= idx_nxt;
            bus.varint_out_err   <= emit_err;
        end else if (bus.varint_out_ready) begin
            bus.varint_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_varint_decoder.sv
// Scoreboard bench for varint_decoder: directed words into a FIFO model, expected
// outputs queued at issue time, a negedge monitor compares each accepted output.
module tb_varint_decoder;
    typedef struct packed {
        logic [63:0] data;
        logic [9:0]  index;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    exp_t        sb[$];
    logic [31:0] fw[$];
    logic [9:0]  fi[$];
    exp_t        got_e;
    int          checks = 0;
    int          errors = 0;
    int          pop_count = 0;

    varint_decoder_if #(.VAL_W(64), .IDX_W(10)) bus ();

    varint_decoder #(.MAX_BYTES(10), .VAL_W(64), .IDX_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Monitor: compare every accepted output against the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && bus.varint_out_valid && bus.varint_out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got data=%h idx=%0d err=%b, required no output",
                         bus.varint_out_data, bus.varint_out_index, bus.varint_out_err);
            end else begin
                got_e = sb.pop_front();
                if (bus.varint_out_data !== got_e.data || bus.varint_out_index !== got_e.index ||
                    bus.varint_out_err !== got_e.err) begin
                    errors++;
                    $display("FAIL out_beat: got data=%h idx=%0d err=%b, required data=%h idx=%0d err=%b",
                             bus.varint_out_data, bus.varint_out_index, bus.varint_out_err,
                             got_e.data, got_e.index, got_e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic refresh();
        bus.varint_in_fifo_empty = (fw.size() == 0);
        bus.varint_in_fifo_data  = (fw.size() != 0) ? fw[0] : '0;
        bus.varint_in_index_data = (fi.size() != 0) ? fi[0] : '0;
    endtask

    task automatic push(input logic [31:0] w, input logic [9:0] idx);
        fw.push_back(w);
        fi.push_back(idx);
        refresh();
    endtask

    task automatic expect_out(input logic [63:0] d, input logic [9:0] idx, input logic e);
        sb.push_back('{data: d, index: idx, err: e});
    endtask

    // One clock: sample pops before the edge, apply them to the FIFO model after it
    task automatic cycle();
        logic pv;
        @(negedge clk);
        pv = bus.varint_in_fifo_pop;
        if (bus.varint_in_fifo_pop !== bus.varint_in_index_pop) begin
            checks++;
            errors++;
            $display("FAIL pop_pair: got data_pop=%b index_pop=%b, required equal",
                     bus.varint_in_fifo_pop, bus.varint_in_index_pop);
        end
        @(posedge clk);
        #1;
        if (pv === 1'b1) begin
            if (fw.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_empty: got pop with FIFO empty, required no pop");
            end else begin
                void'(fw.pop_front());
                void'(fi.pop_front());
                pop_count++;
            end
        end
        refresh();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || fw.size() != 0 || bus.varint_out_valid) && n < 60) begin
            cycle();
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(n < 60), 64'd1);
        chk({name, "_scoreboard_left"}, 64'(sb.size()), 64'd0);
    endtask

    // Hard stop if something hangs despite bounded waits
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int cyc;
        bus.varint_out_ready = 1'b1;
        refresh();
        reset = 1'b1;
        repeat (3) cycle();
        chk("rst_valid", 64'(bus.varint_out_valid), 64'd0);
        chk("rst_data", bus.varint_out_data, 64'd0);
        chk("rst_index", 64'(bus.varint_out_index), 64'd0);
        chk("rst_err", 64'(bus.varint_out_err), 64'd0);
        chk("rst_pop", 64'(bus.varint_in_fifo_pop), 64'd0);
        reset = 1'b0;
        cycle();

        // 1: four single-byte varints in one word, one pop
        p0 = pop_count;
        push(32'h0000_0001, 10'd5);
        expect_out(64'd1, 10'd5, 1'b0);
        repeat (3) expect_out(64'd0, 10'd5, 1'b0);
        drain("t1");
        chk("t1_pops", 64'(pop_count - p0), 64'd1);

        // 2: 0xAC 0x02 -> 300, then two zeros; valid 2 cycles after empty deasserts
        p0 = pop_count;
        push(32'h0000_02AC, 10'd1);
        expect_out(64'd300, 10'd1, 1'b0);
        repeat (2) expect_out(64'd0, 10'd1, 1'b0);
        cyc = 0;
        while (!bus.varint_out_valid && cyc < 10) begin
            cycle();
            cyc++;
        end
        chk("t2_latency", 64'(cyc), 64'd2);
        drain("t2");
        chk("t2_pops", 64'(pop_count - p0), 64'd1);

        // 3: varint spanning two words keeps the first word's index
        p0 = pop_count;
        push(32'h8080_8080, 10'd2);
        push(32'h0000_0001, 10'd3);
        expect_out(64'h1000_0000, 10'd2, 1'b0);
        repeat (3) expect_out(64'd0, 10'd3, 1'b0);
        drain("t3");
        chk("t3_pops", 64'(pop_count - p0), 64'd2);

        // 4: backpressure holds output stable, nothing consumed
        p0 = pop_count;
        bus.varint_out_ready = 1'b0;
        push(32'h0000_02AC, 10'd7);
        expect_out(64'd300, 10'd7, 1'b0);
        repeat (2) expect_out(64'd0, 10'd7, 1'b0);
        cyc = 0;
        while (!bus.varint_out_valid && cyc < 10) begin
            cycle();
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_hold_valid", 64'(bus.varint_out_valid), 64'd1);
            chk("t4_hold_data", bus.varint_out_data, 64'd300);
            chk("t4_hold_index", 64'(bus.varint_out_index), 64'd7);
            chk("t4_hold_pop", 64'(bus.varint_in_fifo_pop), 64'd0);
        end
        chk("t4_stall_pops", 64'(pop_count - p0), 64'd0);
        bus.varint_out_ready = 1'b1;
        drain("t4");
        chk("t4_pops", 64'(pop_count - p0), 64'd1);

        // 5: overlong varint -> single error output, tail discarded
        p0 = pop_count;
        push(32'hFFFF_FFFF, 10'd10);
        push(32'hFFFF_FFFF, 10'd11);
        push(32'hFFFF_FFFF, 10'd12);
        push(32'h0000_0000, 10'd13);
        expect_out(64'hFFFF_FFFF_FFFF_FFFF, 10'd10, 1'b1);
        repeat (3) expect_out(64'd0, 10'd13, 1'b0);
        drain("t5");
        chk("t5_pops", 64'(pop_count - p0), 64'd4);

        // 6: reset mid-varint drops the partial value without popping
        p0 = pop_count;
        push(32'h0000_8080, 10'd20);
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        chk("t6_rst_pop", 64'(bus.varint_in_fifo_pop), 64'd0);
        cycle();
        fw.delete();
        fi.delete();
        refresh();
        chk("t6_rst_valid", 64'(bus.varint_out_valid), 64'd0);
        chk("t6_rst_pops", 64'(pop_count - p0), 64'd0);
        cycle();
        reset = 1'b0;
        cycle();
        push(32'h0000_0007, 10'd21);
        expect_out(64'd7, 10'd21, 1'b0);
        repeat (3) expect_out(64'd0, 10'd21, 1'b0);
        drain("t6");
        chk("t6_pops", 64'(pop_count - p0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
